// File: rtl/mux157_arbiter_pkg.sv
// Shared types and helpers for the 74157 mux arbiter: FSM states, winner
// selection and timer sizing.
package mux157_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SETTLE = 2'd2,
    GRANT  = 2'd3
  } state_t;

  // A lone requester always wins; a tie goes to whoever was not served last.
  function automatic logic next_winner(input logic [1:0] req, input logic last);
    logic w;
    case (req)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      default: w = ~last;
    endcase
    return w;
  endfunction

  // Wide enough to hold the larger of the two limits, including the hold
  // counter's saturation value itself.
  function automatic int timer_width(input int settle_cycles, input int max_hold);
    int m;
    m = (settle_cycles > max_hold) ? settle_cycles : max_hold;
    if (m < 2) m = 2;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mux157_arbiter_if.sv
// Requester/mux-side bundle of the arbiter: request levels in, grants and
// mux control pins out.
interface mux157_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       _en;
  logic       busy;

  modport master (output req, input gnt, input sel, input _en, input busy);
  modport slave  (input req, output gnt, output sel, output _en, output busy);
endinterface

// File: rtl/mux157_arbiter_timer.sv
// Loadable up-counter with clear, enable, saturation and a terminal compare
// that stays true once the terminal value has been reached.
module arb_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term_val,
  input  logic [W-1:0] sat_val,
  output logic         term_hit
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != sat_val)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign term_hit = (count_reg >= term_val);

endmodule

// File: rtl/mux157_arbiter.sv
// Round-robin arbiter for one shared 74157 mux: S only moves while /E is
// high, and a grant is issued only after a programmable settle time.
module mux157_arbiter
  import mux157_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 0
) (
  input  logic              clk,
  input  logic              reset,
  mux157_arbiter_if.slave   bus
);

  localparam int CNT_W = timer_width(SETTLE_CYCLES, MAX_HOLD);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT    = CNT_W'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [1:0] gnt_reg, gnt_next;
  logic       sel_reg, sel_next;
  logic       en_n_reg, en_n_next;
  logic       last_reg, last_next;
  logic       busy_reg;
  logic       settle_hit;
  logic       hold_hit;
  logic       w;

  // The current winner is whatever S already points at.
  assign w = sel_reg;

  arb_timer #(.W(CNT_W)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg != SETTLE),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term_val (SETTLE_TERM),
    .sat_val  (SETTLE_TERM),
    .term_hit (settle_hit)
  );

  arb_timer #(.W(CNT_W)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg != GRANT),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term_val (HOLD_TERM),
    .sat_val  (HOLD_SAT),
    .term_hit (hold_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      sel_reg   <= 1'b0;
      en_n_reg  <= 1'b1;
      last_reg  <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      en_n_reg  <= en_n_next;
      last_reg  <= last_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    en_n_next  = en_n_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        if (bus.req != 2'b00) begin
          sel_next   = next_winner(bus.req, last_reg);
          state_next = SELECT;
        end
      end

      SELECT: begin
        if (!bus.req[w]) begin
          state_next = IDLE;
        end else if (SETTLE_CYCLES == 0) begin
          en_n_next  = 1'b0;
          gnt_next   = w ? 2'b10 : 2'b01;
          state_next = GRANT;
        end else begin
          en_n_next  = 1'b0;
          state_next = SETTLE;
        end
      end

      SETTLE: begin
        if (!bus.req[w]) begin
          en_n_next  = 1'b1;
          state_next = IDLE;
        end else if (settle_hit) begin
          gnt_next   = w ? 2'b10 : 2'b01;
          state_next = GRANT;
        end
      end

      GRANT: begin
        // Release and preemption produce the same outputs, so one path serves both.
        if (!bus.req[w] || ((MAX_HOLD > 0) && hold_hit && bus.req[~w])) begin
          gnt_next   = 2'b00;
          en_n_next  = 1'b1;
          last_next  = w;
          state_next = IDLE;
        end
      end

      default: begin
        gnt_next   = 2'b00;
        en_n_next  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.gnt  = gnt_reg;
  assign bus.sel  = sel_reg;
  assign bus._en  = en_n_reg;
  assign bus.busy = busy_reg;

endmodule

// File: tb/tb_mux157_arbiter.sv
// Directed bench: three arbiter instances (default, MAX_HOLD=4, SETTLE_CYCLES=0)
// driven through one linear sequence, plus a continuous pin-safety monitor.
module tb_mux157_arbiter;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mux157_arbiter_if if_a ();
  mux157_arbiter_if if_b ();
  mux157_arbiter_if if_c ();

  mux157_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(0)) u_def (.clk(clk), .reset(reset), .bus(if_a));
  mux157_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(4)) u_pre (.clk(clk), .reset(reset), .bus(if_b));
  mux157_arbiter #(.SETTLE_CYCLES(0), .MAX_HOLD(0)) u_s0  (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    n_cmp++;
    assert (obs === want) begin
      $display("ok   %s = %0b", tag, obs);
    end else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, want);
    end
  endtask

  // Pin safety: no grant while disabled, S stable while enabled.
  task automatic inv(input string tag, input logic [1:0] g, input logic s, input logic e,
                     input logic ps, input logic pe);
    n_cmp++;
    assert (!((g != 2'b00) && e) && !(!pe && !e && (s != ps))) else begin
      n_bad++;
      $error("FAIL %s: observed gnt=%0b sel=%0b/%0b _en=%0b/%0b expected safe pins",
             tag, g, ps, s, pe, e);
    end
  endtask

  logic [2:0] prev_sel = 3'b000;
  logic [2:0] prev_en  = 3'b111;

  always @(negedge clk) begin
    inv("inv_a", if_a.gnt, if_a.sel, if_a._en, prev_sel[0], prev_en[0]);
    inv("inv_b", if_b.gnt, if_b.sel, if_b._en, prev_sel[1], prev_en[1]);
    inv("inv_c", if_c.gnt, if_c.sel, if_c._en, prev_sel[2], prev_en[2]);
    prev_sel = {if_c.sel, if_b.sel, if_a.sel};
    prev_en  = {if_c._en, if_b._en, if_a._en};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic want_w;
    reset = 1'b1;
    if_a.req = 2'b00;
    if_b.req = 2'b00;
    if_c.req = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state on every instance
    chk("rst_gnt_a", if_a.gnt, 2'b00);  chk("rst_en_a", if_a._en, 1'b1);
    chk("rst_sel_a", if_a.sel, 1'b0);   chk("rst_busy_a", if_a.busy, 1'b0);
    chk("rst_gnt_b", if_b.gnt, 2'b00);  chk("rst_en_b", if_b._en, 1'b1);
    chk("rst_gnt_c", if_c.gnt, 2'b00);  chk("rst_en_c", if_c._en, 1'b1);

    // Single requester 0: SELECT, SETTLE x2, GRANT on the 4th edge
    if_a.req = 2'b01;
    tick(); chk("s0_sel", if_a.sel, 1'b0); chk("s0_en1", if_a._en, 1'b1); chk("s0_busy", if_a.busy, 1'b1);
    tick(); chk("s0_en0", if_a._en, 1'b0); chk("s0_gnt_e2", if_a.gnt, 2'b00);
    tick(); chk("s0_gnt_e3", if_a.gnt, 2'b00);
    tick(); chk("s0_gnt_e4", if_a.gnt, 2'b01); chk("s0_en_g", if_a._en, 1'b0);
    if_a.req = 2'b00;
    tick(); chk("s0_rel_gnt", if_a.gnt, 2'b00); chk("s0_rel_en", if_a._en, 1'b1); chk("s0_rel_busy", if_a.busy, 1'b0);

    // Single requester 1
    if_a.req = 2'b10;
    tick(); chk("s1_sel", if_a.sel, 1'b1); chk("s1_en1", if_a._en, 1'b1);
    repeat (3) tick();
    chk("s1_gnt", if_a.gnt, 2'b10); chk("s1_sel_g", if_a.sel, 1'b1);
    if_a.req = 2'b00;
    tick(); chk("s1_rel_gnt", if_a.gnt, 2'b00);

    // Both requesting: 0 first, unlimited hold, then alternation
    if_a.req = 2'b11;
    repeat (4) tick(); chk("rr_first", if_a.gnt, 2'b01);
    repeat (10) tick(); chk("rr_hold", if_a.gnt, 2'b01);
    if_a.req = 2'b10;
    tick(); chk("rr_rel", if_a.gnt, 2'b00); chk("rr_rel_busy", if_a.busy, 1'b0);
    if_a.req = 2'b11;
    want_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) tick();
      chk("rr_gnt", if_a.gnt, want_w ? 2'b10 : 2'b01);
      chk("rr_sel", if_a.sel, want_w);
      if_a.req = want_w ? 2'b01 : 2'b10;
      tick(); chk("rr_drop", if_a.gnt, 2'b00);
      if_a.req = 2'b11;
      want_w = ~want_w;
    end
    if_a.req = 2'b00;
    tick(); chk("rr_idle", if_a.busy, 1'b0);

    // Abort during SETTLE
    if_a.req = 2'b01;
    tick();
    tick(); chk("ab_en0", if_a._en, 1'b0);
    if_a.req = 2'b00;
    tick(); chk("ab_en", if_a._en, 1'b1); chk("ab_busy", if_a.busy, 1'b0); chk("ab_gnt", if_a.gnt, 2'b00);

    // Preemption after 4 GRANT cycles
    if_b.req = 2'b11;
    repeat (4) tick(); chk("pre_g0", if_b.gnt, 2'b01);
    repeat (3) tick(); chk("pre_g0_hold", if_b.gnt, 2'b01);
    tick(); chk("pre_g0_drop", if_b.gnt, 2'b00); chk("pre_en", if_b._en, 1'b1);
    repeat (4) tick(); chk("pre_g1", if_b.gnt, 2'b10); chk("pre_sel1", if_b.sel, 1'b1);
    repeat (3) tick(); chk("pre_g1_hold", if_b.gnt, 2'b10);

    // Reset mid-GRANT restores last=1, so requester 0 wins next
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_gnt", if_b.gnt, 2'b00); chk("mr_en", if_b._en, 1'b1);
    chk("mr_sel", if_b.sel, 1'b0);  chk("mr_busy", if_b.busy, 1'b0);
    repeat (4) tick(); chk("mr_rr", if_b.gnt, 2'b01);
    if_b.req = 2'b00;
    tick(); chk("mr_rel", if_b.gnt, 2'b00);

    // Zero settle time: grant one edge after SELECT
    if_c.req = 2'b01;
    tick(); chk("z_sel", if_c.sel, 1'b0); chk("z_gnt_e1", if_c.gnt, 2'b00); chk("z_en_e1", if_c._en, 1'b1);
    tick(); chk("z_gnt", if_c.gnt, 2'b01); chk("z_en", if_c._en, 1'b0);
    if_c.req = 2'b00;
    tick(); chk("z_rel", if_c.gnt, 2'b00); chk("z_rel_en", if_c._en, 1'b1);
    if_c.req = 2'b10;
    tick(); chk("z_sel1", if_c.sel, 1'b1);
    tick(); chk("z_gnt1", if_c.gnt, 2'b10);
    if_c.req = 2'b00;
    tick(); chk("z_rel1", if_c.gnt, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
